// File: rtl/addsub_pipe.sv
// addsub_pipe
//   Pipelined W-bit adder/subtractor behind a valid/ready stream interface.
//   The operands are cut into CHUNK-bit slices. Each pipeline stage resolves one
//   slice and registers the carry for the next stage. The operand slices that are
//   still unprocessed shift down towards bit 0 as they travel. The finished sum
//   slices shift in from the top, so the complete sum is aligned after the last
//   stage. The final stage also derives the flags and applies optional signed
//   saturation.
//
// Parameters
//   W      operand/result width, a multiple of CHUNK
//   CHUNK  slice width resolved per stage (STAGES = W/CHUNK)
//   SAT    1 = clamp signed overflow to signed max/min, 0 = wrap
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   in_op      0 = add, 1 = subtract
//   in_cin     carry-in (add) / not-borrow-in (sub)
//   in_x       operand X
//   in_y       operand Y
//   out_valid  result beat present
//   out_ready  downstream accepts result
//   out_s      result (saturated when SAT=1 and overflow)
//   out_cout   carry out of MSB (sub: 1 = no borrow)
//   out_ovf    signed overflow (unsaturated)
//   out_zero   out_s == 0
//   out_neg    out_s[W-1]
module addsub_pipe #(
  parameter int W     = 16,
  parameter int CHUNK = 8,
  parameter int SAT   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic         in_cin,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero,
  output logic         out_neg
);

  localparam int STAGES = W / CHUNK;
  localparam int LAST   = STAGES - 1;

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  // The whole pipe moves together. It only freezes when a result is parked at
  // the output and downstream refuses it.
  logic w_advance;
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance;

  // Per-stage inputs (w_*In) and the values each stage hands onward (w_*Next).
  logic [W-1:0] w_xIn   [STAGES];
  logic [W-1:0] w_yIn   [STAGES];
  logic [W-1:0] w_sIn   [STAGES];
  logic         w_cIn   [STAGES];
  logic         w_vIn   [STAGES];
  logic [W-1:0] w_xNext [STAGES];
  logic [W-1:0] w_yNext [STAGES];
  logic [W-1:0] w_sNext [STAGES];
  logic         w_cNext [STAGES];

  // Subtraction is X + ~Y + cin, so Y is inverted once at the entry.
  assign w_xIn[0] = in_x;
  assign w_yIn[0] = in_op ? ~in_y : in_y;
  assign w_sIn[0] = '0;
  assign w_cIn[0] = in_cin;
  assign w_vIn[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0] w_slice;

    assign w_slice = {1'b0, w_xIn[k][CHUNK-1:0]} + {1'b0, w_yIn[k][CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, w_cIn[k]};

    // The new sum slice enters at the top. After STAGES shifts, slice 0 ends
    // up at bit 0.
    assign w_sNext[k] = (w_sIn[k] >> CHUNK) | (W'(w_slice[CHUNK-1:0]) << (W - CHUNK));
    assign w_xNext[k] = w_xIn[k] >> CHUNK;
    assign w_yNext[k] = w_yIn[k] >> CHUNK;
    assign w_cNext[k] = w_slice[CHUNK];

    if (k < LAST) begin : g_reg
      logic         r_valid;
      logic         r_carry;
      logic [W-1:0] r_x;
      logic [W-1:0] r_y;
      logic [W-1:0] r_s;

      // Inter-stage register. Bubbles travel as r_valid=0, and everything
      // holds while the pipe is frozen.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_carry <= 1'b0;
          r_x     <= '0;
          r_y     <= '0;
          r_s     <= '0;
        end else if (w_advance) begin
          r_valid <= w_vIn[k];
          r_carry <= w_cNext[k];
          r_x     <= w_xNext[k];
          r_y     <= w_yNext[k];
          r_s     <= w_sNext[k];
        end
      end

      assign w_vIn[k+1] = r_valid;
      assign w_cIn[k+1] = r_carry;
      assign w_xIn[k+1] = r_x;
      assign w_yIn[k+1] = r_y;
      assign w_sIn[k+1] = r_s;
    end
  end

  // Final-stage flag logic. The original operand MSBs now sit at bit CHUNK-1 of
  // the shifted operands. Sum bit W-1 is x ^ y ^ (carry into W-1), so the carry
  // into the MSB is recovered from those three bits.
  logic [W-1:0] w_sum;
  logic         w_cout;
  logic         w_xMsb;
  logic         w_yMsb;
  logic         w_cMsb;
  logic         w_ovf;
  logic [W-1:0] w_satS;

  assign w_sum  = w_sNext[LAST];
  assign w_cout = w_cNext[LAST];
  assign w_xMsb = w_xIn[LAST][CHUNK-1];
  assign w_yMsb = w_yIn[LAST][CHUNK-1];
  assign w_cMsb = w_sum[W-1] ^ w_xMsb ^ w_yMsb;
  assign w_ovf  = w_cMsb ^ w_cout;

  // Signed overflow can only happen when both operands share a sign. The sign
  // of X therefore picks the clamp direction.
  always_comb begin
    w_satS = w_sum;
    if ((SAT != 0) && w_ovf) begin
      w_satS = w_xMsb ? SMIN : SMAX;
    end
  end

  // The last stage's leftover shifted operands have no consumer.
  logic w_unused;
  assign w_unused = ^{w_xNext[LAST], w_yNext[LAST]};

  // Output register. This is the final pipeline stage. It holds the complete
  // result and flags stable while downstream stalls.
  logic         r_outValid;
  logic [W-1:0] r_outS;
  logic         r_outCout;
  logic         r_outOvf;
  logic         r_outZero;
  logic         r_outNeg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outS     <= '0;
      r_outCout  <= 1'b0;
      r_outOvf   <= 1'b0;
      r_outZero  <= 1'b0;
      r_outNeg   <= 1'b0;
    end else if (w_advance) begin
      r_outValid <= w_vIn[LAST];
      r_outS     <= w_satS;
      r_outCout  <= w_cout;
      r_outOvf   <= w_ovf;
      r_outZero  <= (w_satS == '0);
      r_outNeg   <= w_satS[W-1];
    end
  end

  assign out_valid = r_outValid;
  assign out_s     = r_outS;
  assign out_cout  = r_outCout;
  assign out_ovf   = r_outOvf;
  assign out_zero  = r_outZero;
  assign out_neg   = r_outNeg;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe
//   Directed bench for addsub_pipe. Three instances share one stimulus:
//     dut0  W=16, wrapping
//     dut1  W=16, saturating
//     dut2  W=8, single stage (driven with the low operand bytes)
module tb_addsub_pipe;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inOp;
  logic        inCin;
  logic [15:0] inX;
  logic [15:0] inY;
  logic        outReady;

  logic        inReady0, outValid0, outCout0, outOvf0, outZero0, outNeg0;
  logic [15:0] outS0;
  logic        inReady1, outValid1, outCout1, outOvf1, outZero1, outNeg1;
  logic [15:0] outS1;
  logic        inReady2, outValid2, outCout2, outOvf2, outZero2, outNeg2;
  logic [7:0]  outS2;

  int nAsserts = 0;
  int nFail    = 0;

  // Values seen one cycle after acceptance. dut0 must still be empty there,
  // and single-stage dut2 must already present its result.
  logic        earlyValid0;
  logic        earlyValid2;
  logic [7:0]  earlyS2;
  logic        earlyCout2;
  logic        earlyOvf2;

  addsub_pipe #(.W(16), .CHUNK(8), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady0),
    .in_op(inOp), .in_cin(inCin), .in_x(inX), .in_y(inY),
    .out_valid(outValid0), .out_ready(outReady), .out_s(outS0),
    .out_cout(outCout0), .out_ovf(outOvf0), .out_zero(outZero0), .out_neg(outNeg0)
  );

  addsub_pipe #(.W(16), .CHUNK(8), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady1),
    .in_op(inOp), .in_cin(inCin), .in_x(inX), .in_y(inY),
    .out_valid(outValid1), .out_ready(outReady), .out_s(outS1),
    .out_cout(outCout1), .out_ovf(outOvf1), .out_zero(outZero1), .out_neg(outNeg1)
  );

  addsub_pipe #(.W(8), .CHUNK(8), .SAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady2),
    .in_op(inOp), .in_cin(inCin), .in_x(inX[7:0]), .in_y(inY[7:0]),
    .out_valid(outValid2), .out_ready(outReady), .out_s(outS2),
    .out_cout(outCout2), .out_ovf(outOvf2), .out_zero(outZero2), .out_neg(outNeg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: one immediate assertion per observed value.
  task automatic checkVal(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one beat with out_ready=1. The task stops at the negedge after the
  // second rising edge, where the W=16 result must be visible.
  task automatic applyStimulus(input logic op, input logic cin,
                               input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    inValid = 1'b1;
    inOp    = op;
    inCin   = cin;
    inX     = x;
    inY     = y;
    @(posedge clk);
    @(negedge clk);
    inValid     = 1'b0;
    earlyValid0 = outValid0;
    earlyValid2 = outValid2;
    earlyS2     = outS2;
    earlyCout2  = outCout2;
    earlyOvf2   = outOvf2;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag,
                             input logic [15:0] s0, input logic c, input logic o,
                             input logic z0, input logic n0,
                             input logic [15:0] s1, input logic z1, input logic n1,
                             input logic [7:0] s2, input logic c2, input logic o2);
    checkVal({tag, "_lat_early"}, earlyValid0, 1'b0);
    checkVal({tag, "_valid"}, outValid0, 1'b1);
    checkVal({tag, "_s"}, outS0, s0);
    checkVal({tag, "_cout"}, outCout0, c);
    checkVal({tag, "_ovf"}, outOvf0, o);
    checkVal({tag, "_zero"}, outZero0, z0);
    checkVal({tag, "_neg"}, outNeg0, n0);
    checkVal({tag, "_sat_valid"}, outValid1, 1'b1);
    checkVal({tag, "_sat_s"}, outS1, s1);
    checkVal({tag, "_sat_cout"}, outCout1, c);
    checkVal({tag, "_sat_ovf"}, outOvf1, o);
    checkVal({tag, "_sat_zero"}, outZero1, z1);
    checkVal({tag, "_sat_neg"}, outNeg1, n1);
    checkVal({tag, "_w8_valid"}, earlyValid2, 1'b1);
    checkVal({tag, "_w8_s"}, earlyS2, s2);
    checkVal({tag, "_w8_cout"}, earlyCout2, c2);
    checkVal({tag, "_w8_ovf"}, earlyOvf2, o2);
  endtask

  logic [15:0] streamX [4];
  logic [15:0] streamY [4];
  logic [15:0] streamS [4];
  logic [31:0] readyPat;
  logic [31:0] validPat;
  int          pushIdx;
  int          popIdx;
  logic        held;
  logic [15:0] heldS;

  initial begin
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inOp     = 1'b0;
    inCin    = 1'b0;
    inX      = '0;
    inY      = '0;
    outReady = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_valid", outValid0, 1'b0);
    checkVal("rst_s", outS0, 16'h0000);
    checkVal("rst_zero", outZero0, 1'b0);
    checkVal("rst_in_ready", inReady0, 1'b1);
    rst_n = 1'b1;

    // Fill the pipe against a stalled sink, then reset mid-stream
    outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b1; inOp = 1'b0; inCin = 1'b0; inX = 16'h1234; inY = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    inX = 16'h0001; inY = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    checkVal("stall_valid", outValid0, 1'b1);
    checkVal("stall_s", outS0, 16'h2345);
    checkVal("stall_in_ready", inReady0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkVal("stall_hold_s", outS0, 16'h2345);
    #2 rst_n = 1'b0;
    #1;
    checkVal("midrst_valid", outValid0, 1'b0);
    checkVal("midrst_s", outS0, 16'h0000);
    checkVal("midrst_flags", {outCout0, outOvf0, outZero0, outNeg0}, 4'b0000);
    checkVal("midrst_sat_valid", outValid1, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    outReady = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("postrst_empty", outValid0, 1'b0);

    // Directed vectors: s0 c o z0 n0 | sat s1 z1 n1 | w8 s2 c2 o2
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0001);
    checkOutput("add_ffff_1", 16'h0000, 1, 0, 1, 0, 16'h0000, 1, 0, 8'h00, 1, 0);
    applyStimulus(1'b0, 1'b0, 16'h7FFF, 16'h0001);
    checkOutput("add_7fff_1", 16'h8000, 0, 1, 0, 1, 16'h7FFF, 0, 0, 8'h00, 1, 0);
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0001);
    checkOutput("sub_0_1", 16'hFFFF, 0, 0, 0, 1, 16'hFFFF, 0, 1, 8'hFF, 0, 0);
    applyStimulus(1'b1, 1'b1, 16'h8000, 16'h0001);
    checkOutput("sub_8000_1", 16'h7FFF, 1, 1, 0, 0, 16'h8000, 0, 1, 8'hFF, 0, 0);
    applyStimulus(1'b0, 1'b0, 16'h00FF, 16'h0001);
    checkOutput("add_00ff_1", 16'h0100, 0, 0, 0, 0, 16'h0100, 0, 0, 8'h00, 1, 0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 16'h4321);
    checkOutput("add_cin", 16'h5556, 0, 0, 0, 0, 16'h5556, 0, 0, 8'h56, 0, 0);
    applyStimulus(1'b1, 1'b1, 16'h5555, 16'h5555);
    checkOutput("sub_equal", 16'h0000, 1, 0, 1, 0, 16'h0000, 1, 0, 8'h00, 1, 0);
    applyStimulus(1'b0, 1'b0, 16'h007F, 16'h0001);
    checkOutput("add_007f_1", 16'h0080, 0, 0, 0, 0, 16'h0080, 0, 0, 8'h80, 0, 1);
    applyStimulus(1'b0, 1'b0, 16'h8000, 16'h8000);
    checkOutput("add_8000_8000", 16'h0000, 1, 1, 1, 0, 16'h8000, 0, 1, 8'h00, 0, 0);

    // Short stream with input gaps and output stalls, checked in order
    streamX[0] = 16'h0001; streamY[0] = 16'h0001; streamS[0] = 16'h0002;
    streamX[1] = 16'h0010; streamY[1] = 16'h0020; streamS[1] = 16'h0030;
    streamX[2] = 16'h1000; streamY[2] = 16'h2000; streamS[2] = 16'h3000;
    streamX[3] = 16'h00FF; streamY[3] = 16'h00FF; streamS[3] = 16'h01FE;
    readyPat = 32'b1011_0011_0100_1111_0110_1101_1100_0101;
    validPat = 32'b1111_1101_1011_0111_1110_1011_0111_1011;
    pushIdx  = 0;
    popIdx   = 0;
    held     = 1'b0;
    heldS    = '0;
    inOp     = 1'b0;
    inCin    = 1'b0;
    for (int cyc = 0; cyc < 60 && popIdx < 4; cyc++) begin
      @(negedge clk);
      outReady = readyPat[cyc % 32];
      inValid  = (pushIdx < 4) && validPat[cyc % 32];
      inX      = streamX[pushIdx % 4];
      inY      = streamY[pushIdx % 4];
      #1;
      if (held) begin
        checkVal("hold_valid", outValid0, 1'b1);
        checkVal("hold_s", outS0, heldS);
      end
      if (outValid0 && outReady) begin
        checkVal($sformatf("stream_beat%0d", popIdx), outS0, streamS[popIdx]);
        popIdx++;
        held = 1'b0;
      end else if (outValid0) begin
        held  = 1'b1;
        heldS = outS0;
      end else begin
        held = 1'b0;
      end
      if (inValid && inReady0) pushIdx++;
    end
    checkVal("stream_count", popIdx, 4);
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (4) @(negedge clk);
    checkVal("stream_no_dup", outValid0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
